count_display: RTL and testbench
================================

COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 SHALL have parameter REFRESH_COUNT, default 100_000, clock cycles each digit is shown (minimum 2).
REQ-002 SHALL have port clk_100mhz  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port value  input  8  unsigned binary value to display.
REQ-005 SHALL have port value_valid  input  1  one-cycle strobe that requests a display update from value.
REQ-006 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port an  output  8  active-low digit anodes; an[0] is the rightmost digit.
REQ-008 SHALL have port seg  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-009 SHALL have port dp  output  1  active-low decimal point; it is held at 1 (off).

Function
REQ-010 SHALL implement a converter FSM with the states IDLE, CONVERT and COMMIT.
REQ-011 In IDLE with value_valid=1, SHALL capture value into the shift register, clear the 12-bit BCD accumulator and the iteration count, and enter CONVERT.
REQ-012 In CONVERT, each cycle SHALL add 3 to every BCD nibble >=5, then shift {BCD, shift register} left by 1 (double-dabble).
REQ-013 SHALL leave CONVERT for COMMIT after exactly 8 shift cycles; the 3-bit iteration count wraps from 7 to 0 on exit.
REQ-014 In COMMIT, SHALL copy the BCD accumulator to the display register {hundreds, tens, ones} and return to IDLE.
REQ-015 busy SHALL be 1 exactly while the FSM is in CONVERT or COMMIT, which is 9 cycles after the capture edge.
REQ-016 The new digits SHALL first drive seg on the cycle after the COMMIT edge; total latency from the value_valid edge is 10 cycles.
REQ-017 value_valid asserted while busy=1 SHALL be ignored; it is not queued.
REQ-018 The display register SHALL change only in COMMIT, so the digits shown never display partial results.
REQ-019 SHALL keep a refresh counter running from 0 to REFRESH_COUNT-1; on wrap, the digit index advances 0->1->2->0.
REQ-020 Digit index k SHALL drive an[k] low; all other anodes are high, and an[7:3] are always high.
REQ-021 Digit 0 SHALL show ones, digit 1 tens and digit 2 hundreds, using standard 0-9 glyphs (for example, 0=7'b1000000 and 8=7'b0000000).
REQ-022 Leading-zero blanking: hundreds SHALL be blanked when hundreds=0, and tens SHALL be blanked when hundreds=0 and tens=0; ones is never blanked.
REQ-023 A blanked slot SHALL drive an=8'hFF and seg=7'b1111111 for the whole slot, and scanning timing is unaffected.
REQ-024 The refresh and scan logic SHALL run independently of the converter FSM, with no stall while busy.
REQ-025 an and seg SHALL be registered outputs, free of glitches between slots.

Reset
REQ-026 When reset_n=0 at a clock edge, the next state SHALL be: FSM=IDLE, busy=0, display register=0, digit index=0, refresh counter=0.
REQ-027 The registered outputs after reset SHALL be an=8'b1111_1110, seg=7'b1000000 ("0") and dp=1.
REQ-028 Reset SHALL override value_valid on the same edge and SHALL abort a conversion in progress, discarding it with no COMMIT.

Verification
REQ-029 Reset check: hold reset_n=0 for 3 cycles, then release -> an=FE, seg=1000000 and busy=0 until the first refresh wrap.
REQ-030 Conversion of 255: value=8'd255 with a 1-cycle strobe -> busy=1 for 9 cycles; with REFRESH_COUNT=4, scanning shows ones=5 (0010010), tens=5 and hundreds=2 (0100100).
REQ-031 Blanking of 7: value=8'd7 -> the digit-0 slot shows seg=1111000 and the digit-1 and digit-2 slots show an=FF, seg=1111111.
REQ-032 Strobe while busy: strobe 8'd10, then strobe 8'd99 three cycles later -> the display shows 10 ("1","0", hundreds blanked), and 99 is never shown.
REQ-033 Reset mid-conversion: strobe 8'd200, then reset_n=0 on the 4th busy cycle -> busy=0 the cycle after, and the display shows "0" with no "200" ever appearing.
REQ-034 Scan wrap: with REFRESH_COUNT=4 and value 123, an SHALL follow FE,FD,FB,FE... changing every 4 cycles, with seg showing 3, 2, 1 respectively.

Source files
------------

// File: rtl/count_display.sv
// Byte-to-BCD converter (double-dabble) driving a multiplexed 3-digit seven-segment display
// with leading-zero blanking; the display register only ever holds fully converted values.
module count_display #(
   parameter int REFRESH_COUNT = 100_000
) (
   input  logic       clk_100mhz,
   input  logic       reset_n,
   input  logic [7:0] value,
   input  logic       value_valid,
   output logic       busy,
   output logic [7:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CW = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
   localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_COUNT - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] COMMIT  = 2'd2;

   logic [1:0]    state_reg;
   logic [7:0]    shift_reg;
   logic [11:0]   bcd_reg;
   logic [11:0]   bcd_adj;
   logic [2:0]    iter_reg;
   logic [11:0]   disp_reg;
   logic [CW-1:0] refresh_reg;
   logic [1:0]    digit_reg;
   logic [7:0]    an_reg;
   logic [6:0]    seg_reg;
   logic [7:0]    an_next;
   logic [6:0]    seg_next;
   logic [3:0]    nibble;
   logic          blank;

   // Add-3 correction applied to each BCD nibble before it is shifted.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk_100mhz) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         shift_reg <= '0;
         bcd_reg   <= '0;
         iter_reg  <= '0;
         disp_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (value_valid) begin
                  shift_reg <= value;
                  bcd_reg   <= '0;
                  iter_reg  <= '0;
                  state_reg <= CONVERT;
               end
            end
            CONVERT: begin
               {bcd_reg, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
               iter_reg <= iter_reg + 3'd1;
               if (iter_reg == 3'd7) begin
                  state_reg <= COMMIT;
               end
            end
            COMMIT: begin
               disp_reg  <= bcd_reg;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy = (state_reg != IDLE);

   always_ff @(posedge clk_100mhz) begin
      if (!reset_n) begin
         refresh_reg <= '0;
         digit_reg   <= 2'd0;
      end else if (refresh_reg == REFRESH_LAST) begin
         refresh_reg <= '0;
         digit_reg   <= (digit_reg == 2'd2) ? 2'd0 : digit_reg + 2'd1;
      end else begin
         refresh_reg <= refresh_reg + 1'b1;
      end
   end

   always_comb begin
      nibble = disp_reg[3:0];
      blank  = 1'b0;
      case (digit_reg)
         2'd0: begin
            nibble = disp_reg[3:0];
            blank  = 1'b0;
         end
         2'd1: begin
            nibble = disp_reg[7:4];
            blank  = (disp_reg[11:4] == 8'd0);
         end
         2'd2: begin
            nibble = disp_reg[11:8];
            blank  = (disp_reg[11:8] == 4'd0);
         end
         default: blank = 1'b1;
      endcase
   end

   always_comb begin
      case (nibble)
         4'd0:    seg_next = 7'b1000000;
         4'd1:    seg_next = 7'b1111001;
         4'd2:    seg_next = 7'b0100100;
         4'd3:    seg_next = 7'b0110000;
         4'd4:    seg_next = 7'b0011001;
         4'd5:    seg_next = 7'b0010010;
         4'd6:    seg_next = 7'b0000010;
         4'd7:    seg_next = 7'b1111000;
         4'd8:    seg_next = 7'b0000000;
         4'd9:    seg_next = 7'b0010000;
         default: seg_next = 7'b1111111;
      endcase
      an_next = ~(8'd1 << digit_reg);
      if (blank) begin
         seg_next = 7'b1111111;
         an_next  = 8'hFF;
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (!reset_n) begin
         an_reg  <= 8'b1111_1110;
         seg_reg <= 7'b1000000;
      end else begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
      end
   end

   assign an  = an_reg;
   assign seg = seg_reg;
   assign dp  = 1'b1;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: a cycle-numbered reference model predicts busy, an, seg and dp
// from decimal arithmetic on the most recently accepted value.
module tb_count_display;

   localparam int RC = 4;

   logic       clk_100mhz = 1'b0;
   logic       reset_n    = 1'b0;
   logic [7:0] value      = 8'd0;
   logic       value_valid = 1'b0;
   logic       busy;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   int total = 0;
   int bad   = 0;

   // Reference model state: k counts edges since the last reset edge.
   int k        = 0;
   int busy_end = -100;
   int pend_at  = -1;
   int pend_val = 0;
   int shown    = 0;
   logic       exp_busy;
   logic [7:0] exp_an;
   logic [6:0] exp_seg;

   count_display #(.REFRESH_COUNT(RC)) dut (
      .clk_100mhz (clk_100mhz),
      .reset_n    (reset_n),
      .value      (value),
      .value_valid(value_valid),
      .busy       (busy),
      .an         (an),
      .seg        (seg),
      .dp         (dp)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Advance one clock edge and update the model's expectation for the outputs after it.
   task automatic tick();
      int idx;
      int digit;
      bit blanked;
      @(posedge clk_100mhz);
      if (!reset_n) begin
         k = 0; shown = 0; pend_at = -1; busy_end = -100;
      end else begin
         k++;
         if (value_valid && k >= busy_end + 2) begin
            busy_end = k + 8;
            pend_val = value;
            pend_at  = k + 10;
         end
         if (k == pend_at) shown = pend_val;
      end
      exp_busy = (k <= busy_end);
      idx = (k == 0) ? 0 : ((k - 1) / RC) % 3;
      case (idx)
         0: begin digit = shown % 10;        blanked = 1'b0;        end
         1: begin digit = (shown / 10) % 10; blanked = (shown < 10);  end
         default: begin digit = shown / 100; blanked = (shown < 100); end
      endcase
      exp_an  = blanked ? 8'hFF : ~(8'd1 << idx);
      exp_seg = blanked ? 7'b1111111 : glyph(digit);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({busy, an, seg, dp} !== {1'b0, 8'hFE, 7'b1000000, 1'b1}) begin
            bad++;
            $display("FAIL reset_hold: got busy=%b an=%h seg=%b dp=%b want busy=0 an=fe seg=1000000 dp=1", busy, an, seg, dp);
         end
      end
      reset_n = 1'b1;
      for (int i = 0; i < RC; i++) begin
         tick();
         total++;
         if ({busy, an, seg} !== {1'b0, 8'hFE, 7'b1000000}) begin
            bad++;
            $display("FAIL reset_release: cycle %0d got busy=%b an=%h seg=%b want busy=0 an=fe seg=1000000", i, busy, an, seg);
         end
      end
      $display("reset: checked %0d cycles", 3 + RC);
   endtask

   task automatic test_value(input logic [7:0] v, input int cycles, input string name);
      int busy_cycles = 0;
      value = v; value_valid = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         tick();
         value_valid = 1'b0;
         if (busy === 1'b1) busy_cycles++;
         total++;
         if (busy !== exp_busy) begin
            bad++;
            $display("FAIL %s_busy: cycle %0d got %b want %b", name, i, busy, exp_busy);
         end
         total++;
         if ({an, seg, dp} !== {exp_an, exp_seg, 1'b1}) begin
            bad++;
            $display("FAIL %s_display: cycle %0d got an=%h seg=%b dp=%b want an=%h seg=%b dp=1", name, i, an, seg, dp, exp_an, exp_seg);
         end
      end
      total++;
      if (busy_cycles != 9) begin
         bad++;
         $display("FAIL %s_busy_len: got %0d want 9", name, busy_cycles);
      end
      $display("%s: value=%0d busy_cycles=%0d", name, v, busy_cycles);
   endtask

   task automatic test_back_to_back();
      value = 8'd10; value_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         value_valid = 1'b0;
         if (i == 2) begin value = 8'd99; value_valid = 1'b1; end
         total++;
         if ({busy, an, seg} !== {exp_busy, exp_an, exp_seg}) begin
            bad++;
            $display("FAIL back_to_back: cycle %0d got busy=%b an=%h seg=%b want busy=%b an=%h seg=%b", i, busy, an, seg, exp_busy, exp_an, exp_seg);
         end
         total++;
         if (seg === 7'b0010000) begin
            bad++;
            $display("FAIL back_to_back_99: cycle %0d got seg=%b want no 9 glyph", i, seg);
         end
      end
      $display("back_to_back: strobed 10 then 99, model shows %0d", shown);
   endtask

   task automatic test_reset_mid();
      value = 8'd200; value_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         value_valid = 1'b0;
         total++;
         if (busy !== exp_busy) begin
            bad++;
            $display("FAIL reset_mid_busy: cycle %0d got %b want %b", i, busy, exp_busy);
         end
         if (i == 2) reset_n = 1'b0;
      end
      reset_n = 1'b1;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_abort: got busy=%b want 0", busy);
      end
      for (int i = 0; i < 30; i++) begin
         tick();
         total++;
         if ({busy, an, seg} !== {exp_busy, exp_an, exp_seg} || seg === 7'b0100100) begin
            bad++;
            $display("FAIL reset_mid_display: cycle %0d got busy=%b an=%h seg=%b want busy=%b an=%h seg=%b", i, busy, an, seg, exp_busy, exp_an, exp_seg);
         end
      end
      $display("reset_mid: conversion of 200 aborted, model shows %0d", shown);
   endtask

   task automatic test_random();
      int gap;
      for (int n = 0; n < 40; n++) begin
         value = 8'($urandom_range(0, 255));
         value_valid = 1'b1;
         gap = $urandom_range(1, 16);
         for (int i = 0; i < gap; i++) begin
            tick();
            value_valid = 1'b0;
            total++;
            if ({busy, an, seg, dp} !== {exp_busy, exp_an, exp_seg, 1'b1}) begin
               bad++;
               $display("FAIL random: strobe %0d cycle %0d got busy=%b an=%h seg=%b dp=%b want busy=%b an=%h seg=%b dp=1", n, i, busy, an, seg, dp, exp_busy, exp_an, exp_seg);
            end
         end
         $display("random: strobe %0d value=%0d gap=%0d shown=%0d", n, value, gap, shown);
      end
   endtask

   initial begin
      test_reset();
      test_value(8'd255, 30, "convert_255");
      test_value(8'd7, 30, "blank_7");
      test_value(8'd123, 30, "scan_123");
      test_value(8'd40, 30, "convert_40");
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
